// File: rtl/usb_uart_io_if.sv
// Bus bundle between a CPU-side host and the usb_uart_io bridge.
// Carries the CPU I/O port signals and the USB serial core byte stream.
interface usb_uart_io_if;
    logic       io_addr;
    logic       io_rd;
    logic       io_wr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       irq;
    logic       uart_tx_ready;
    logic [7:0] uart_tx_data;
    logic       uart_tx_strobe;
    logic [7:0] uart_rx_data;
    logic       uart_rx_strobe;

    // Environment side: drives CPU strobes and the USB core's byte stream.
    modport master (
        output io_addr, io_rd, io_wr, io_wdata,
        input  io_rdata, irq,
        output uart_tx_ready,
        input  uart_tx_data, uart_tx_strobe,
        output uart_rx_data, uart_rx_strobe
    );

    // Bridge side.
    modport slave (
        input  io_addr, io_rd, io_wr, io_wdata,
        output io_rdata, irq,
        input  uart_tx_ready,
        output uart_tx_data, uart_tx_strobe,
        input  uart_rx_data, uart_rx_strobe
    );
endinterface

// File: rtl/usb_uart_io.sv
// CPU I/O port bridge to a USB serial core: TX and RX byte FIFOs, status/control
// register and optional interrupt. Define USB_UART_IRQ_EN to implement the
// interrupt enables and irq output; otherwise irq is tied low.
module usb_uart_io #(
    parameter int unsigned TX_AW = 4,
    parameter int unsigned RX_AW = 4
) (
    input logic          clk,
    input logic          reset,
    usb_uart_io_if.slave bus
);
    localparam int unsigned TxDepth = 1 << TX_AW;
    localparam int unsigned RxDepth = 1 << RX_AW;

    logic [7:0]     tx_mem [TxDepth];
    logic [7:0]     rx_mem [RxDepth];
    logic [TX_AW:0] tx_wptr_q, tx_rptr_q;
    logic [RX_AW:0] rx_wptr_q, rx_rptr_q;
    logic           tx_ovf_q, rx_ovf_q;
    logic           tx_strobe_q;
    logic [7:0]     tx_data_q;
    logic [7:0]     rdata_q;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic rx_push_req, rx_push, rx_pop, rx_ovf_set;
    logic data_rd, stat_rd;
    logic rx_ie, tx_ie;
    logic [7:0] status;

    // Full/empty from extended pointers; push on full succeeds only with a same-cycle pop.
    always_comb begin
        tx_empty    = (tx_wptr_q == tx_rptr_q);
        tx_full     = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                      (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
        rx_empty    = (rx_wptr_q == rx_rptr_q);
        rx_full     = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                      (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);

        tx_push_req = bus.io_wr & ~bus.io_addr;
        // Strobe_q gate keeps transfer pulses at least one idle cycle apart.
        tx_pop      = ~tx_empty & bus.uart_tx_ready & ~tx_strobe_q;
        tx_push     = tx_push_req & (~tx_full | tx_pop);
        tx_ovf_set  = tx_push_req & ~tx_push;

        data_rd     = bus.io_rd & ~bus.io_addr;
        stat_rd     = bus.io_rd & bus.io_addr;
        rx_push_req = bus.uart_rx_strobe;
        rx_pop      = data_rd & ~rx_empty;
        rx_push     = rx_push_req & (~rx_full | rx_pop);
        rx_ovf_set  = rx_push_req & ~rx_push;

        status      = {2'b00, tx_ie, rx_ie, tx_ovf_q, rx_ovf_q, ~tx_full, ~rx_empty};
    end

    // FIFO storage; contents are discarded on reset through the pointers only.
    always_ff @(posedge clk) begin
        if (reset && tx_push) begin
            tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.io_wdata;
        end
        if (reset && rx_push) begin
            rx_mem[rx_wptr_q[RX_AW-1:0]] <= bus.uart_rx_data;
        end
    end

    // Pointers, sticky overflow flags, TX strobe/data and CPU read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_strobe_q <= 1'b0;
            tx_data_q   <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;

            tx_strobe_q <= tx_pop;
            if (tx_pop) tx_data_q <= tx_mem[tx_rptr_q[TX_AW-1:0]];

            // A new overflow in the same cycle as the status read wins over the clear.
            if (tx_ovf_set)   tx_ovf_q <= 1'b1;
            else if (stat_rd) tx_ovf_q <= 1'b0;
            if (rx_ovf_set)   rx_ovf_q <= 1'b1;
            else if (stat_rd) rx_ovf_q <= 1'b0;

            if (data_rd) begin
                rdata_q <= rx_empty ? 8'h00 : rx_mem[rx_rptr_q[RX_AW-1:0]];
            end else if (stat_rd) begin
                rdata_q <= status;
            end
        end
    end

`ifdef USB_UART_IRQ_EN
    logic rx_ie_q, tx_ie_q, irq_q;

    // Interrupt enables from control writes; irq registered from current state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_ie_q <= 1'b0;
            tx_ie_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (bus.io_wr && bus.io_addr) begin
                rx_ie_q <= bus.io_wdata[4];
                tx_ie_q <= bus.io_wdata[5];
            end
            irq_q <= (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty);
        end
    end

    assign rx_ie   = rx_ie_q;
    assign tx_ie   = tx_ie_q;
    assign bus.irq = irq_q;
`else
    assign rx_ie   = 1'b0;
    assign tx_ie   = 1'b0;
    assign bus.irq = 1'b0;
`endif

    assign bus.io_rdata       = rdata_q;
    assign bus.uart_tx_strobe = tx_strobe_q;
    assign bus.uart_tx_data   = tx_data_q;
endmodule

// File: tb/tb_usb_uart_io.sv
// Bench for usb_uart_io: a vector table for the basic port/FIFO behaviour, then
// hand-written sequences for overflow, full-FIFO pop/push, reset and interrupt.
module tb_usb_uart_io;
`ifdef USB_UART_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass = 0;

    usb_uart_io_if bus_if ();

    usb_uart_io #(.TX_AW(4), .RX_AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       addr;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
        logic       txr;
        logic [7:0] rxd;
        logic       rxs;
        logic [7:0] e_rdata;
        logic       e_stb;
        logic [7:0] e_txd;
        logic       e_irq;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic a, input logic rd, input logic wr,
                                input logic [7:0] wd, input logic txr,
                                input logic [7:0] rxd, input logic rxs,
                                input logic [7:0] er, input logic es,
                                input logic [7:0] et, input logic ei);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.wdata = wd; v.txr = txr;
        v.rxd = rxd; v.rxs = rxs; v.e_rdata = er; v.e_stb = es; v.e_txd = et;
        v.e_irq = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    // Apply one cycle of CPU/RX inputs, then sample #1 after the edge.
    task automatic cyc(input logic a, input logic rd, input logic wr, input logic [7:0] wd,
                       input logic rxs, input logic [7:0] rxd);
        bus_if.io_addr        = a;
        bus_if.io_rd          = rd;
        bus_if.io_wr          = wr;
        bus_if.io_wdata       = wd;
        bus_if.uart_rx_strobe = rxs;
        bus_if.uart_rx_data   = rxd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic status_rd(input string name, input logic [7:0] exp);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk(name, bus_if.io_rdata, exp);
    endtask

    task automatic data_rd(input string name, input logic [7:0] exp);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk(name, bus_if.io_rdata, exp);
    endtask

    initial begin
        int  cnt;
        logic prev;

        //              a  rd wr wd     txr rxd    rxs  rdata  stb txd    irq
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 8'h00, 0);
        vecs[2]  = mk(0, 0, 1, 8'h41, 1, 8'h00, 0, 8'h02, 0, 8'h00, 0);
        vecs[3]  = mk(0, 0, 1, 8'h42, 1, 8'h00, 0, 8'h02, 1, 8'h41, 0);
        vecs[4]  = mk(0, 0, 1, 8'h43, 1, 8'h00, 0, 8'h02, 0, 8'h41, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h02, 1, 8'h42, 0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h02, 0, 8'h42, 0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h02, 1, 8'h43, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h02, 0, 8'h43, 0);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0, 8'h55, 1, 8'h02, 0, 8'h43, 0);
        vecs[10] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h55, 0, 8'h43, 0);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h55, 0, 8'h43, 0);
        vecs[12] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h43, 0);
        vecs[13] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h02, 0, 8'h43, 0);
        vecs[14] = mk(0, 1, 0, 8'h00, 0, 8'hA5, 1, 8'h00, 0, 8'h43, 0);
        vecs[15] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h03, 0, 8'h43, 0);
        vecs[16] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'hA5, 0, 8'h43, 0);
        vecs[17] = mk(1, 0, 1, 8'h30, 0, 8'h00, 0, 8'hA5, 0, 8'h43, 0);
        vecs[18] = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, {2'b00, IrqEn, IrqEn, 4'b0010},
                      0, 8'h43, IrqEn);
        vecs[19] = mk(1, 0, 1, 8'h00, 0, 8'h00, 0, {2'b00, IrqEn, IrqEn, 4'b0010},
                      0, 8'h43, IrqEn);
        vecs[20] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, {2'b00, IrqEn, IrqEn, 4'b0010},
                      0, 8'h43, 0);

        bus_if.uart_tx_ready = 1'b0;
        reset = 1'b0;
        idle();
        idle();
        chk("reset.rdata", bus_if.io_rdata, 8'h00);
        chk("reset.strobe", {7'b0, bus_if.uart_tx_strobe}, 8'h00);
        chk("reset.irq", {7'b0, bus_if.irq}, 8'h00);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            bus_if.uart_tx_ready = vecs[i].txr;
            cyc(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].rxs, vecs[i].rxd);
            chk($sformatf("v%0d.rdata", i), bus_if.io_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d.strobe", i), {7'b0, bus_if.uart_tx_strobe}, {7'b0, vecs[i].e_stb});
            chk($sformatf("v%0d.txdata", i), bus_if.uart_tx_data, vecs[i].e_txd);
            chk($sformatf("v%0d.irq", i), {7'b0, bus_if.irq}, {7'b0, vecs[i].e_irq});
        end

        // TX overflow: 17th byte dropped while the core is not ready.
        bus_if.uart_tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
        status_rd("txovf.status", 8'h08);
        status_rd("txovf.cleared", 8'h00);
        bus_if.uart_tx_ready = 1'b1;
        cnt = 0;
        prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (bus_if.uart_tx_strobe) begin
                chk($sformatf("drain%0d.data", cnt), bus_if.uart_tx_data, 8'(8'h10 + cnt));
                chk($sformatf("drain%0d.adjacent", cnt), {7'b0, prev}, 8'h00);
                cnt++;
            end
            prev = bus_if.uart_tx_strobe;
        end
        chk("drain.count", 8'(cnt), 8'd16);
        status_rd("drain.status", 8'h02);

        // RX full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i));
        status_rd("rxfull.status", 8'h03);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
        chk("rxfull.pushpop", bus_if.io_rdata, 8'h60);
        status_rd("rxfull.noovf", 8'h03);
        for (int i = 1; i < 16; i++) data_rd($sformatf("rxdrain%0d", i), 8'(8'h60 + i));
        data_rd("rxdrain.last", 8'h99);
        data_rd("rxdrain.empty", 8'h00);

        // RX overflow without pop, then load both FIFOs for the reset test.
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h80 + i));
        status_rd("rxovf.status", 8'h07);
        status_rd("rxovf.cleared", 8'h03);
        bus_if.uart_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hC1 + i), 1'b0, 8'h00);
        data_rd("prereset.rdata", 8'h80);

        // Reset mid-operation with strobes present.
        reset = 1'b0;
        bus_if.uart_tx_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h11);
        chk("midreset.rdata", bus_if.io_rdata, 8'h00);
        chk("midreset.txdata", bus_if.uart_tx_data, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h11);
        chk("midreset.strobe", {7'b0, bus_if.uart_tx_strobe}, 8'h00);
        #1;
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (bus_if.uart_tx_strobe) cnt++;
        end
        chk("postreset.nostrobe", 8'(cnt), 8'd0);
        status_rd("postreset.status", 8'h02);
        data_rd("postreset.rxempty", 8'h00);

        // Interrupt on RX available (tied low when the feature is absent).
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
        chk("irq.after_ctl", {7'b0, bus_if.irq}, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
        chk("irq.push_cycle", {7'b0, bus_if.irq}, 8'h00);
        idle();
        chk("irq.raised", {7'b0, bus_if.irq}, {7'b0, IrqEn});
        data_rd("irq.rxdata", 8'h77);
        chk("irq.pop_cycle", {7'b0, bus_if.irq}, {7'b0, IrqEn});
        idle();
        chk("irq.cleared", {7'b0, bus_if.irq}, 8'h00);
        status_rd("irq.status", {3'b000, IrqEn, 4'b0010});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_uart_io.md
USB_UART_IO -- requirements
Module: usb_uart_io

Interface
REQ-001 SHALL provide parameter TX_AW, default 4, TX FIFO address width (depth 2^TX_AW bytes).
REQ-002 SHALL provide parameter RX_AW, default 4, RX FIFO address width (depth 2^RX_AW bytes).
REQ-003 clk  input  1  system clock, same domain as the USB serial core's uart interface.
REQ-004 reset  input  1  synchronous, active-low.
REQ-005 io_addr  input  1  port select: 0 = data, 1 = status/control.
REQ-006 io_rd  input  1  single-cycle CPU read strobe.
REQ-007 io_wr  input  1  single-cycle CPU write strobe.
REQ-008 io_wdata  input  8  CPU write data.
REQ-009 io_rdata  output  8  registered CPU read data.
REQ-010 irq  output  1  registered, active-high interrupt request.
REQ-011 uart_tx_ready  input  1  USB serial core can accept a byte.
REQ-012 uart_tx_data  output  8  byte to USB host.
REQ-013 uart_tx_strobe  output  1  one-cycle transfer pulse to USB core.
REQ-014 uart_rx_data  input  8  byte from USB host.
REQ-015 uart_rx_strobe  input  1  one-cycle pulse, uart_rx_data valid.

Function
REQ-016 Both FIFOs SHALL use (AW+1)-bit read/write pointers; empty = pointers equal; full = MSBs differ and low bits equal.
REQ-017 io_wr with io_addr=0: push io_wdata into TX FIFO; if full, discard the byte and set sticky tx_ovf.
REQ-018 TX drain: when TX non-empty, uart_tx_ready=1 and uart_tx_strobe was 0 last cycle, assert uart_tx_strobe for exactly one cycle with uart_tx_data = head byte, and pop.
REQ-019 uart_tx_strobe SHALL never be asserted on two consecutive cycles; uart_tx_data SHALL be stable while strobe high.
REQ-020 uart_rx_strobe: push uart_rx_data into RX FIFO; if full and no same-cycle pop, discard and set sticky rx_ovf.
REQ-021 Simultaneous push and pop on a full FIFO SHALL both succeed without overflow; on an empty FIFO the pop is ignored and the push succeeds.
REQ-022 io_rd with io_addr=0: io_rdata = RX head on next cycle, and pop; if empty, io_rdata = 0x00 and no pop.
REQ-023 io_rd with io_addr=1: io_rdata next cycle = {2'b0, tx_ie, rx_ie, tx_ovf, rx_ovf, tx_not_full, rx_avail} (bit 7 down to 0); both ovf flags clear on that cycle unless re-set the same cycle (set wins).
REQ-024 io_wr with io_addr=1: rx_ie <= io_wdata[4], tx_ie <= io_wdata[5]; other bits ignored.
REQ-025 io_rdata SHALL hold its last value when io_rd is low.
REQ-026 irq SHALL be registered: (rx_ie & rx_avail) | (tx_ie & TX empty), one-cycle latency from state change.
REQ-027 Pointer arithmetic SHALL wrap modulo 2^(AW+1) with no special casing.

Reset
REQ-028 On clk edge with reset=0: all pointers 0, tx_ovf=rx_ovf=0, rx_ie=tx_ie=0, uart_tx_strobe=0, uart_tx_data=0x00, io_rdata=0x00, irq=0.
REQ-029 Reset mid-operation SHALL discard all FIFO contents; strobes present during reset are ignored.

Configuration
REQ-030 Macro USB_UART_IRQ_EN: when defined, REQ-024 and REQ-026 apply.
REQ-031 When USB_UART_IRQ_EN undefined: irq tied 0, rx_ie/tx_ie not implemented, status bits 5:4 read 0, control writes ignored; all else unchanged.

Verification
REQ-032 Write 0x41,0x42,0x43 to port 0 with uart_tx_ready=1 -> three single-cycle strobes, data 0x41,0x42,0x43 in order, never adjacent cycles.
REQ-033 uart_tx_ready=0, write 17 bytes (TX_AW=4) -> 17th dropped, status read = 0x08 (tx_ovf, tx_not_full=0), next status read tx_ovf=0.
REQ-034 Pulse uart_rx_strobe with 0x55, then io_rd port 0 -> io_rdata=0x55 next cycle; second read -> 0x00, status bit0=0.
REQ-035 Fill RX to 16, same-cycle uart_rx_strobe 0x99 and io_rd port 0 -> head returned, 0x99 stored, rx_ovf=0.
REQ-036 USB_UART_IRQ_EN defined, write 0x10 to port 1, pulse uart_rx_strobe -> irq=1 two cycles later; drain RX -> irq=0 next cycle.
REQ-037 Assert reset=0 with bytes in both FIFOs -> after release status reads 0x02, no uart_tx_strobe issued.
